// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: op codes and the
// single-step fold used to reduce operands left to right.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // One step of the left fold on a single bit column. The inverting ops
  // share the base fold here; the inversion is applied once to the final
  // result, not per step. PASS (and reserved) keep the accumulator, so
  // operand 0 falls through unchanged.
  function automatic logic fold_op(input logic acc, input logic opnd, input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: fold_op = acc & opnd;
      OP_OR,  OP_NOR:  fold_op = acc | opnd;
      OP_XOR, OP_XNOR: fold_op = acc ^ opnd;
      default:         fold_op = acc;
    endcase
  endfunction

  // True for the ops whose final fold result is complemented.
  function automatic logic op_inverts(input logic [2:0] op);
    op_inverts = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register slice: holds a valid bit and a payload, and
// advances whenever it is empty or its consumer takes the current item.
module logic_pipe_stage
  import logic_unit_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Load a new item (or a bubble) whenever the slice advances; the payload
  // is only overwritten by real data so it stays put while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Two-stage pipelined multi-operand bitwise logic unit. Stage 1 registers
// the operand bundle and op; the fold and result flags are computed between
// the stages and registered in stage 2. Also counts delivered results.
module pipelined_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_ops,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_err,
  output logic [CNT_W-1:0]        done_cnt
);

  localparam int OPS_W = NUM_IN * WIDTH;
  localparam int S1_W  = OPS_W + 3;
  localparam int S2_W  = WIDTH + 2;

  logic              s1_valid;
  logic [S1_W-1:0]   s1_data;
  logic              s2_in_ready;
  logic [S2_W-1:0]   s2_data;
  logic [OPS_W-1:0]  s1_ops;
  logic [2:0]        s1_op;
  logic [WIDTH-1:0]  fold_data;
  logic              fold_zero;
  logic              fold_err;

  logic_pipe_stage #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_ops}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign s1_ops = s1_data[OPS_W-1:0];
  assign s1_op  = s1_data[S1_W-1 -: 3];

  // Left-fold every bit column across the operands, then apply the final
  // inversion for NAND/NOR/XNOR; the reserved op forces an all-zero result
  // flagged as an error so the transaction still completes.
  always_comb begin
    fold_data = s1_ops[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        fold_data[b] = fold_op(fold_data[b], s1_ops[k*WIDTH + b], s1_op);
      end
    end
    if (op_inverts(s1_op)) begin
      fold_data = ~fold_data;
    end
    fold_err = (s1_op == OP_RSVD);
    if (fold_err) begin
      fold_data = '0;
    end
    fold_zero = (fold_data == '0);
  end

  logic_pipe_stage #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({fold_err, fold_zero, fold_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_data = s2_data[WIDTH-1:0];
  assign out_zero = s2_data[WIDTH];
  assign out_err  = s2_data[WIDTH+1];

  // Count each result taken downstream; the counter wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Directed and scoreboard bench for pipelined_logic_unit (W=8, N=4, CNT_W=4).
module tb_pipelined_logic_unit;
  import logic_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ops;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_zero;
  logic        out_err;
  logic [3:0]  done_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  exp_cnt;

  pipelined_logic_unit #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // Independent reference: {err, zero, data} for a 4-operand bundle.
  function automatic logic [9:0] ref_res(input logic [31:0] v, input logic [2:0] op);
    logic [7:0] a, b, c, d, r;
    a = v[7:0]; b = v[15:8]; c = v[23:16]; d = v[31:24];
    case (op)
      3'd0:    r = a & b & c & d;
      3'd1:    r = a | b | c | d;
      3'd2:    r = a ^ b ^ c ^ d;
      3'd3:    r = ~(a & b & c & d);
      3'd4:    r = ~(a | b | c | d);
      3'd5:    r = ~(a ^ b ^ c ^ d);
      3'd6:    r = a;
      default: r = 8'h00;
    endcase
    return {op == 3'd7, r == 8'h00, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] ops);
    in_valid = v;
    in_op    = op;
    in_ops   = ops;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_valid got=%b exp=0", out_valid); end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_data got=%h exp=00", out_data); end
    total++; if (out_zero !== 1'b0 || out_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_flags got=%b%b exp=00", out_zero, out_err); end
    total++; if (done_cnt !== 4'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d exp=0", done_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_and();
    drive(1'b1, OP_AND, pk(8'hFF, 8'hF0, 8'h3C, 8'hFF));
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL and_in_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, OP_AND, 32'h0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL and_early_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL and_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'h30) begin bad++; $display("[TB] FAIL and_data got=%h exp=30", out_data); end
    total++; if (out_zero !== 1'b0 || out_err !== 1'b0) begin bad++; $display("[TB] FAIL and_flags got=%b%b exp=00", out_zero, out_err); end
    tick();
    exp_cnt++;
    total++; if (done_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL and_cnt got=%0d exp=%0d", done_cnt, exp_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL and_after_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, OP_XNOR, pk(8'h01, 8'h02, 8'h04, 8'h08));
    tick();
    drive(1'b1, OP_NOR, pk(8'h00, 8'h00, 8'h00, 8'h00));
    tick();
    drive(1'b0, OP_AND, 32'h0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hF0) begin bad++; $display("[TB] FAIL b2b_xnor got=%b/%h exp=1/f0", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_nor got=%b/%h exp=1/ff", out_valid, out_data); end
    tick();
    exp_cnt += 4'd2;
    total++; if (done_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL b2b_cnt got=%0d exp=%0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, OP_OR, pk(8'h01, 8'h02, 8'h04, 8'h08));
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_rdy_a got=%b exp=1", in_ready); end
    tick();
    drive(1'b1, OP_XOR, pk(8'hFF, 8'h0F, 8'h00, 8'h01));
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_rdy_b got=%b exp=1", in_ready); end
    tick();
    drive(1'b1, OP_AND, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_rdy_c got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin bad++; $display("[TB] FAIL bp_head got=%b/%h exp=1/0f", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin bad++; $display("[TB] FAIL bp_stable1 got=%b/%h exp=1/0f", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0F || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_stable2 got=%b/%h/%b exp=1/0f/0", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_rdy got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, OP_AND, 32'h0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hF1) begin bad++; $display("[TB] FAIL bp_second got=%b/%h exp=1/f1", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin bad++; $display("[TB] FAIL bp_third got=%b/%h exp=1/ff", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained got=%b exp=0", out_valid); end
    exp_cnt += 4'd3;
    total++; if (done_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL bp_cnt got=%0d exp=%0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_reserved();
    drive(1'b1, OP_RSVD, pk(8'h12, 8'h34, 8'h56, 8'h78));
    tick();
    drive(1'b0, OP_AND, 32'h0);
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin bad++; $display("[TB] FAIL rsvd_data got=%b/%h exp=1/00", out_valid, out_data); end
    total++; if (out_zero !== 1'b1 || out_err !== 1'b1) begin bad++; $display("[TB] FAIL rsvd_flags got=%b%b exp=11", out_zero, out_err); end
    tick();
    exp_cnt++;
    total++; if (done_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL rsvd_cnt got=%0d exp=%0d", done_cnt, exp_cnt); end
    drive(1'b1, OP_PASS, pk(8'hA5, 8'h00, 8'hFF, 8'h3C));
    tick();
    drive(1'b0, OP_AND, 32'h0);
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin bad++; $display("[TB] FAIL pass_data got=%b/%h exp=1/a5", out_valid, out_data); end
    total++; if (out_zero !== 1'b0 || out_err !== 1'b0) begin bad++; $display("[TB] FAIL pass_flags got=%b%b exp=00", out_zero, out_err); end
    tick();
    exp_cnt++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, OP_OR, pk(8'h11, 8'h22, 8'h44, 8'h88));
    tick();
    drive(1'b1, OP_AND, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    tick();
    drive(1'b0, OP_AND, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (done_cnt !== 4'd0) begin bad++; $display("[TB] FAIL arst_cnt got=%0d exp=0", done_cnt); end
    exp_cnt = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_stale%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, OP_PASS, {24'h0, 8'(i)});
      tick();
    end
    drive(1'b0, OP_AND, 32'h0);
    total++; if (done_cnt !== 4'd15) begin bad++; $display("[TB] FAIL wrap_15 got=%0d exp=15", done_cnt); end
    total++; if (out_data !== 8'h0F) begin bad++; $display("[TB] FAIL wrap_data got=%h exp=0f", out_data); end
    tick();
    total++; if (done_cnt !== 4'd0) begin bad++; $display("[TB] FAIL wrap_0 got=%0d exp=0", done_cnt); end
    tick();
    total++; if (done_cnt !== 4'd1) begin bad++; $display("[TB] FAIL wrap_1 got=%0d exp=1", done_cnt); end
    tick();
    exp_cnt = 4'd1;
  endtask

  task automatic test_random();
    logic [9:0] q[$];
    logic [9:0] exp;
    for (int i = 0; i < 320; i++) begin
      if (i < 300) begin
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom());
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        drive(1'b0, OP_AND, 32'h0);
        out_ready = 1'b1;
      end
      #1;
      if (in_valid && in_ready) q.push_back(ref_res(in_ops, in_op));
      if (out_valid && out_ready) begin
        exp_cnt++;
        total++;
        if (q.size() == 0) begin
          bad++; $display("[TB] FAIL rand_extra got=%h exp=none", out_data);
        end else begin
          exp = q.pop_front();
          if ({out_err, out_zero, out_data} !== exp) begin
            bad++; $display("[TB] FAIL rand_result got=%b%b/%h exp=%b%b/%h", out_err, out_zero, out_data, exp[9], exp[8], exp[7:0]);
          end
        end
      end
      tick();
    end
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL rand_lost got=%0d exp=0", q.size()); end
    total++; if (done_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL rand_cnt got=%0d exp=%0d", done_cnt, exp_cnt); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_ops    = 32'h0;
    out_ready = 1'b1;
    exp_cnt   = 4'd0;
    test_reset();
    test_and();
    test_back_to_back();
    test_backpressure();
    test_reserved();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
